// File: rtl/load_store_bus.sv
// load_store_bus: MIPS load/store unit driving an Avalon-style memory bus with
// lane steering, load lane masking, alignment checks and a waitrequest timeout.
module load_store_bus #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] readdata_eb,
    output logic [1:0]  lsb_bits,
    output logic [5:0]  opcode_q
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    localparam int CW = $clog2(MAX_WAIT + 1);
    state_t state, state_n;
    logic [CW-1:0] wait_cnt;
    logic [31:0] addr_q, wdata_q;
    logic [5:0] op_q;
    logic err_q, is_load, is_store, misaligned, accept, active, timeout;
    always_comb begin
        is_load    = opcode inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        is_store   = opcode inside {6'h28, 6'h29, 6'h2B};
        misaligned = (opcode[1:0] == 2'b01 && addr[0]) || (opcode[1:0] == 2'b11 && addr[1:0] != 2'b00);
        accept     = state == IDLE && req_valid && (is_load || is_store) && !misaligned;
        active     = state == READ || state == WRITE;
        timeout    = waitrequest && wait_cnt == CW'(MAX_WAIT - 1);
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:        if (accept) state_n = is_load ? READ : WRITE;
            READ, WRITE: state_n = !waitrequest ? RESP : timeout ? IDLE : state;
            RESP:        state_n = IDLE;
            default:     state_n = IDLE;
        endcase
    end
    // Only accepted opcodes are latched, and all of them have bit 5 set, so a
    // cleared op_q yields no lanes and no store data.
    always_comb begin
        busy       = state != IDLE;
        done       = state == RESP;
        error      = err_q;
        read       = state == READ;
        write      = state == WRITE;
        address    = {addr_q[31:2], 2'b00};
        byteenable = !op_q[5]            ? 4'b0000 :
                     op_q[1:0] == 2'b00  ? 4'b0001 << addr_q[1:0] :
                     op_q[1:0] == 2'b01  ? (addr_q[1] ? 4'b1100 : 4'b0011) :
                     op_q[1:0] == 2'b11  ? 4'b1111 : 4'b0000;
        writedata  = op_q == 6'h28 ? {4{wdata_q[7:0]}} :
                     op_q == 6'h29 ? {2{wdata_q[15:0]}} :
                     op_q == 6'h2B ? wdata_q : 32'h0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            op_q        <= '0;
            wait_cnt    <= '0;
            err_q       <= 1'b0;
            readdata_eb <= '0;
            lsb_bits    <= '0;
            opcode_q    <= '0;
        end else begin
            err_q <= (state == IDLE && req_valid && !accept) || (active && timeout);
            if (accept) begin
                addr_q   <= addr;
                wdata_q  <= wdata;
                op_q     <= opcode;
                wait_cnt <= '0;
            end else if (active && waitrequest) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == READ && !waitrequest) begin
                readdata_eb <= readdata & {{8{byteenable[3]}}, {8{byteenable[2]}},
                                           {8{byteenable[1]}}, {8{byteenable[0]}}};
                lsb_bits    <= addr_q[1:0];
                opcode_q    <= op_q;
            end
        end
    end
endmodule

// File: tb/tb_load_store_bus.sv
// tb_load_store_bus: directed vector table plus hand sequences for timeout and
// asynchronous reset behaviour of load_store_bus.
module tb_load_store_bus;
    logic clk = 0, reset = 1, req_valid = 0, waitrequest = 0;
    logic [5:0] opcode = 0;
    logic [31:0] addr = 0, wdata = 0, readdata = 0;
    logic [31:0] address, writedata, readdata_eb;
    logic read, write, busy, done, error;
    logic [3:0] byteenable;
    logic [1:0] lsb_bits;
    logic [5:0] opcode_q;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    load_store_bus #(.MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .opcode(opcode),
        .addr(addr), .wdata(wdata), .address(address), .read(read),
        .write(write), .byteenable(byteenable), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata), .busy(busy),
        .done(done), .error(error), .readdata_eb(readdata_eb),
        .lsb_bits(lsb_bits), .opcode_q(opcode_q)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, wd, rd;
        int          waits;
        logic        err, ld;
        logic [3:0]  be;
        logic [31:0] wdo, rdeb;
        logic [1:0]  lsb;
        logic [5:0]  opq;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input vec_t v);
        logic [31:0] exp_addr;
        logic [1:0] exp_rw;
        logic bad;
        int n;
        opcode = v.op; addr = v.a; wdata = v.wd; readdata = v.rd;
        req_valid = 1; waitrequest = 1;
        tick;
        req_valid = 0; opcode = 6'h3F; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
        if (v.err) begin
            chk("err_pulse", error, 1);
            chk("err_busy", busy, 0);
            chk("err_strobe", {read, write}, 0);
            chk("err_done", done, 0);
            tick;
            chk("err_clear", error, 0);
            return;
        end
        exp_addr = {v.a[31:2], 2'b00};
        exp_rw = v.ld ? 2'b10 : 2'b01;
        chk("strobe", {read, write}, exp_rw);
        chk("address", address, exp_addr);
        chk("byteenable", byteenable, v.be);
        if (!v.ld) chk("writedata", writedata, v.wdo);
        n = 0; bad = 0;
        while ((read || write) && n < 300) begin
            if (address !== exp_addr || byteenable !== v.be || {read, write} !== exp_rw ||
                (!v.ld && writedata !== v.wdo) || done || error) bad = 1;
            waitrequest = n < v.waits;
            tick;
            n++;
        end
        waitrequest = 0;
        chk("strobe_cycles", n, v.waits + 1);
        chk("stable", bad, 0);
        chk("done", done, 1);
        chk("no_err_with_done", error, 0);
        chk("resp_busy", busy, 1);
        chk("readdata_eb", readdata_eb, v.rdeb);
        chk("lsb_bits", lsb_bits, v.lsb);
        chk("opcode_q", opcode_q, v.opq);
        tick;
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int n;
        logic seen_done;
        //          op     addr          wdata         readdata      w  err ld be       wdo           rdeb          lsb opq
        vecs[0]  = '{6'h24, 32'h0000_1003, 32'h0,        32'hAABB_CCDD, 0, 0, 1, 4'b1000, 32'h0,        32'hAA00_0000, 3, 6'h24};
        vecs[1]  = '{6'h20, 32'h0000_0011, 32'h0,        32'h1122_3344, 0, 0, 1, 4'b0010, 32'h0,        32'h0000_3300, 1, 6'h20};
        vecs[2]  = '{6'h21, 32'h0000_2002, 32'h0,        32'hDEAD_BEEF, 2, 0, 1, 4'b1100, 32'h0,        32'hDEAD_0000, 2, 6'h21};
        vecs[3]  = '{6'h25, 32'h0000_4000, 32'h0,        32'hCAFE_F00D, 0, 0, 1, 4'b0011, 32'h0,        32'h0000_F00D, 0, 6'h25};
        vecs[4]  = '{6'h23, 32'h0000_8004, 32'h0,        32'h1234_5678, 1, 0, 1, 4'b1111, 32'h0,        32'h1234_5678, 0, 6'h23};
        vecs[5]  = '{6'h28, 32'h0000_3001, 32'h1234_56A5, 32'hFFFF_FFFF, 0, 0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h1234_5678, 0, 6'h23};
        vecs[6]  = '{6'h2B, 32'h0000_5008, 32'h89AB_CDEF, 32'hFFFF_FFFF, 0, 0, 0, 4'b1111, 32'h89AB_CDEF, 32'h1234_5678, 0, 6'h23};
        vecs[7]  = '{6'h29, 32'h0000_6000, 32'hFFFF_1234, 32'hFFFF_FFFF, 0, 0, 0, 4'b0011, 32'h1234_1234, 32'h1234_5678, 0, 6'h23};
        vecs[8]  = '{6'h29, 32'h0000_2002, 32'h0000_BEEF, 32'hFFFF_FFFF, 4, 0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h1234_5678, 0, 6'h23};
        vecs[9]  = '{6'h23, 32'h0000_0001, 32'h0,        32'h0,        0, 1, 1, 4'b0000, 32'h0,        32'h0,        0, 6'h00};
        vecs[10] = '{6'h21, 32'h0000_0003, 32'h0,        32'h0,        0, 1, 1, 4'b0000, 32'h0,        32'h0,        0, 6'h00};
        vecs[11] = '{6'h22, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 1, 4'b0000, 32'h0,        32'h0,        0, 6'h00};
        vecs[12] = '{6'h2B, 32'h0000_0002, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0,        0, 6'h00};
        vecs[13] = '{6'h29, 32'h0000_0001, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0,        0, 6'h00};
        vecs[14] = '{6'h20, 32'h0000_0010, 32'h0,        32'h0000_0080, 0, 0, 1, 4'b0001, 32'h0,        32'h0000_0080, 0, 6'h20};

        #12;
        chk("rst_address", address, 0);
        chk("rst_strobes", {read, write, busy, done, error}, 0);
        chk("rst_byteenable", byteenable, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_readdata_eb", readdata_eb, 0);
        chk("rst_lsb_opq", {lsb_bits, opcode_q}, 0);
        @(posedge clk); #1 reset = 0;
        tick;

        for (int i = 0; i < 14; i++) do_txn(vecs[i]);

        // Bus never answers: the access must give up after MAX_WAIT strobe cycles.
        opcode = 6'h23; addr = 32'h100; req_valid = 1; waitrequest = 1;
        tick;
        req_valid = 0;
        n = 0; seen_done = 0;
        while (read && n < 50) begin
            if (done) seen_done = 1;
            tick;
            n++;
        end
        chk("timeout_read_cycles", n, 8);
        chk("timeout_error", error, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_no_done", {seen_done, done}, 0);
        tick;
        chk("timeout_err_clear", error, 0);

        // Reset mid-READ drops the strobe without waiting for a clock edge.
        opcode = 6'h23; addr = 32'h200; req_valid = 1; waitrequest = 1;
        tick;
        req_valid = 0;
        chk("pre_reset_read", read, 1);
        #2 reset = 1;
        #1;
        chk("async_read_drop", read, 0);
        chk("async_busy", busy, 0);
        chk("async_done_err", {done, error}, 0);
        chk("async_address", address, 0);
        @(posedge clk); #1 reset = 0; waitrequest = 0;
        tick;
        chk("post_reset_quiet", {busy, done, error}, 0);
        do_txn(vecs[14]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_bus.md
LOAD_STORE_BUS -- requirements
Module: load_store_bus

Interface
REQ-001 The module SHALL have parameter MAX_WAIT, default 255, giving the maximum number of waitrequest cycles tolerated per access.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port req_valid, input, 1, CPU memory request strobe, sampled only in IDLE.
REQ-005 The module SHALL have port opcode, input, 6, MIPS opcode: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
REQ-006 The module SHALL have port addr, input, 32, byte address of the access.
REQ-007 The module SHALL have port wdata, input, 32, store data with the value right-aligned.
REQ-008 The module SHALL have port address, output, 32, bus word address: latched addr with bits [1:0] forced to 0.
REQ-009 The module SHALL have ports read and write, output, 1 each, bus strobes.
REQ-010 The module SHALL have port byteenable, output, 4, bus lane enables.
REQ-011 The module SHALL have port writedata, output, 32, lane-positioned store data.
REQ-012 The module SHALL have ports waitrequest, input, 1, and readdata, input, 32, bus responses.
REQ-013 The module SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-014 The module SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 The module SHALL have port error, output, 1, one-cycle pulse for a misaligned access, unknown opcode or timeout.
REQ-016 The module SHALL have ports readdata_eb, output, 32; lsb_bits, output, 2; and opcode_q, output, 6; these are held load results for the downstream byte/half extraction stage.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WRITE and RESP.
REQ-018 In IDLE with req_valid=1, the module SHALL latch addr, opcode and wdata, and go to READ (load opcodes) or WRITE (store opcodes) on the next edge.
REQ-019 Halfword accesses with addr[0]=1, word accesses with addr[1:0]!=0, and unknown opcodes SHALL stay in IDLE, issue no bus strobe, and pulse error on the next cycle.
REQ-020 byteenable SHALL be: byte accesses, one-hot 1<<addr[1:0]; halfword accesses, 4'b0011 or 4'b1100 selected by addr[1]; word accesses, 4'b1111.
REQ-021 writedata SHALL be: SB, wdata[7:0] replicated on all four lanes; SH, wdata[15:0] replicated on both halves; SW, wdata unchanged.
REQ-022 read (in READ) or write (in WRITE) SHALL be asserted, with address, byteenable and writedata stable, on every cycle until a cycle with waitrequest=0.
REQ-023 On the cycle with waitrequest=0 in READ, the module SHALL register readdata into readdata_eb with disabled lanes zeroed, register latched addr[1:0] into lsb_bits and the opcode into opcode_q, and go to RESP.
REQ-024 On the cycle with waitrequest=0 in WRITE, the module SHALL go to RESP with readdata_eb unchanged.
REQ-025 RESP SHALL last exactly one cycle with done=1 and return to IDLE; req_valid in RESP SHALL be ignored.
REQ-026 Minimum latency SHALL be 3 cycles from the req_valid edge to done (IDLE, READ/WRITE, RESP).
REQ-027 A wait counter SHALL clear on entry to READ/WRITE and increment each cycle with waitrequest=1; on reaching MAX_WAIT it SHALL drop the strobe, pulse error, and return to IDLE without done.
REQ-028 readdata_eb, lsb_bits and opcode_q SHALL hold their values until the next successful load.
REQ-029 done and error SHALL never be high in the same cycle.

Reset
REQ-030 While reset=1, state SHALL be IDLE and all outputs SHALL be 0, regardless of clk.
REQ-031 Reset asserted during READ or WRITE SHALL drop read/write immediately (asynchronously) and abandon the access with no done or error.

Verification
REQ-032 LBU at addr 0x1003, readdata 0xAABBCCDD, waitrequest=0 -> address 0x1000, byteenable 4'b1000, readdata_eb 0xAA000000, lsb_bits 3, done 3 cycles after the request.
REQ-033 SH addr 0x2002, wdata 0x0000BEEF, waitrequest high for 4 cycles -> write held 5 cycles, byteenable 4'b1100, writedata 0xBEEFBEEF, then one done pulse.
REQ-034 LW at addr 0x0001 -> no read strobe, error pulse, busy stays 0; LH at 0x0003 -> same response.
REQ-035 LW with waitrequest stuck at 1 and MAX_WAIT=8 -> read high for 8 cycles, then error pulse, IDLE, no done.
REQ-036 Reset asserted mid-READ -> read=0 in the same cycle, busy=0, no done; the next LB at 0x10 (readdata 0x00000080) -> readdata_eb 0x00000080, lsb_bits 0.
